// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls the front of the
// pipe until the memory acknowledges, and fills the MEM/WB register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        zero,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WriteData,
  input  logic [31:0] PCBranch,
  input  logic [4:0]  WriteReg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        Stall,
  output logic        PCSrc,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [31:0] wb_ReadData,
  output logic [31:0] wb_ALUOut,
  output logic [4:0]  wb_WriteReg,
  output logic        AddrErr,
  output logic        TimeoutErr
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wb_regwrite_q, wb_regwrite_d;
  logic                wb_memtoreg_q, wb_memtoreg_d;
  logic [DATA_W-1:0]   wb_readdata_q, wb_readdata_d;
  logic [DATA_W-1:0]   wb_aluout_q, wb_aluout_d;
  logic [REG_W-1:0]    wb_writereg_q, wb_writereg_d;
  logic                addr_err_q, addr_err_d;
  logic                timeout_err_q, timeout_err_d;

  logic access;
  logic aligned;
  logic is_load;
  logic start;
  logic cnt_at_limit;
  logic req_raw;
  logic stall_raw;

  // PCBranch passes straight to the fetch stage; it is only carried here.
  logic unused_pcbranch;
  assign unused_pcbranch = ^PCBranch;

  // A simultaneous load+store is handled as a plain store.
  assign access       = MemtoReg | MemWrite;
  assign aligned      = (ALUOut[1:0] == 2'b00);
  assign is_load      = MemtoReg & ~MemWrite;
  assign start        = (state_q == S_IDLE) & access & aligned;
  assign cnt_at_limit = (cnt_q == CNT_W'(TIMEOUT));

  assign req_raw   = start | (state_q == S_WAIT);
  assign stall_raw = start | ((state_q == S_WAIT) & ~mem_ack & ~cnt_at_limit);

  // Reset kills the request and stall immediately, without waiting for a clock.
  assign mem_req   = req_raw & ~RESET;
  assign Stall     = stall_raw & ~RESET;
  assign mem_we    = mem_req & MemWrite;
  assign mem_addr  = mem_req ? {ALUOut[31:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? WriteData : '0;
  assign PCSrc     = Branch & zero & ~Stall;

  // Next state and MEM/WB contents; a bubble is the default on every edge.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wb_regwrite_d = 1'b0;
    wb_memtoreg_d = 1'b0;
    wb_readdata_d = '0;
    wb_aluout_d   = '0;
    wb_writereg_d = '0;
    addr_err_d    = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (aligned) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            addr_err_d = 1'b1;
          end
        end else begin
          wb_regwrite_d = RegWrite & (WriteReg != '0);
          wb_aluout_d   = ALUOut;
          wb_writereg_d = WriteReg;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          wb_regwrite_d = RegWrite & is_load & (WriteReg != '0);
          wb_memtoreg_d = is_load;
          wb_readdata_d = is_load ? mem_rdata : '0;
          wb_aluout_d   = ALUOut;
          wb_writereg_d = WriteReg;
        end else if (cnt_at_limit) begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_readdata_q <= '0;
      wb_aluout_q   <= '0;
      wb_writereg_q <= '0;
      addr_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_readdata_q <= wb_readdata_d;
      wb_aluout_q   <= wb_aluout_d;
      wb_writereg_q <= wb_writereg_d;
      addr_err_q    <= addr_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign wb_RegWrite = wb_regwrite_q;
  assign wb_MemtoReg = wb_memtoreg_q;
  assign wb_ReadData = wb_readdata_q;
  assign wb_ALUOut   = wb_aluout_q;
  assign wb_WriteReg = wb_writereg_q;
  assign AddrErr     = addr_err_q;
  assign TimeoutErr  = timeout_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_access_stage;

  localparam int TB_TIMEOUT = 15;

  logic        CLK, RESET;
  logic        RegWrite, MemtoReg, MemWrite, Branch, zero;
  logic [31:0] ALUOut, WriteData, PCBranch;
  logic [4:0]  WriteReg;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        Stall, PCSrc;
  logic        wb_RegWrite, wb_MemtoReg;
  logic [31:0] wb_ReadData, wb_ALUOut;
  logic [4:0]  wb_WriteReg;
  logic        AddrErr, TimeoutErr;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  mem_access_stage #(.TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .Branch(Branch), .zero(zero),
    .ALUOut(ALUOut), .WriteData(WriteData), .PCBranch(PCBranch),
    .WriteReg(WriteReg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .Stall(Stall), .PCSrc(PCSrc),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_ReadData(wb_ReadData), .wb_ALUOut(wb_ALUOut), .wb_WriteReg(wb_WriteReg),
    .AddrErr(AddrErr), .TimeoutErr(TimeoutErr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_n is the 1-based cycle number within the current memory access
  // (0 = no access in progress). An access lasts at most TIMEOUT+2 cycles.
  int          m_n = 0;
  logic        e_rw = 0, e_mtr = 0, e_aerr = 0, e_terr = 0;
  logic [31:0] e_rd = 0, e_alu = 0;
  logic [4:0]  e_wr = 0;

  always @(posedge CLK or posedge RESET) begin
    logic acc, al, ld;
    if (RESET) begin
      m_n = 0; e_rw = 0; e_mtr = 0; e_rd = 0; e_alu = 0; e_wr = 0; e_aerr = 0; e_terr = 0;
    end else begin
      acc = MemtoReg | MemWrite;
      al  = (ALUOut[1:0] == 2'b00);
      e_rw = 0; e_mtr = 0; e_rd = 0; e_alu = 0; e_wr = 0; e_aerr = 0; e_terr = 0;
      if (m_n == 0) begin
        if (acc && al) m_n = 2;
        else if (acc) e_aerr = 1;
        else begin
          e_rw = RegWrite && (WriteReg != 0);
          e_alu = ALUOut;
          e_wr = WriteReg;
        end
      end else if (mem_ack) begin
        ld = MemtoReg && !MemWrite;
        e_rw = ld && RegWrite && (WriteReg != 0);
        e_mtr = ld;
        e_rd = ld ? mem_rdata : 32'h0;
        e_alu = ALUOut;
        e_wr = WriteReg;
        m_n = 0;
      end else if (m_n == TB_TIMEOUT + 2) begin
        e_terr = 1;
        m_n = 0;
      end else begin
        m_n++;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge CLK) begin
    logic acc, al, e_req, e_stall, e_we;
    logic [31:0] e_addr, e_wdata;
    if (chk_en) begin
      acc = MemtoReg | MemWrite;
      al  = (ALUOut[1:0] == 2'b00);
      if (RESET) begin
        e_req = 0; e_stall = 0;
      end else begin
        e_req   = (m_n == 0 && acc && al) || (m_n >= 2);
        e_stall = (m_n == 0 && acc && al) || (m_n >= 2 && !mem_ack && m_n != TB_TIMEOUT + 2);
      end
      e_we    = e_req && MemWrite;
      e_addr  = e_req ? {ALUOut[31:2], 2'b00} : 32'h0;
      e_wdata = e_req ? WriteData : 32'h0;
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("Stall", 32'(Stall), 32'(e_stall));
      chk("PCSrc", 32'(PCSrc), 32'(Branch && zero && !e_stall));
      chk("wb_RegWrite", 32'(wb_RegWrite), 32'(e_rw));
      chk("wb_MemtoReg", 32'(wb_MemtoReg), 32'(e_mtr));
      chk("wb_ReadData", wb_ReadData, e_rd);
      chk("wb_ALUOut", wb_ALUOut, e_alu);
      chk("wb_WriteReg", 32'(wb_WriteReg), 32'(e_wr));
      chk("AddrErr", 32'(AddrErr), 32'(e_aerr));
      chk("TimeoutErr", 32'(TimeoutErr), 32'(e_terr));
    end
  end

  task automatic set_in(input logic rw, mtr, mw, br, z, input logic [31:0] alu, wd,
                        input logic [4:0] wr, input logic ack, input logic [31:0] rd);
    RegWrite = rw; MemtoReg = mtr; MemWrite = mw; Branch = br; zero = z;
    ALUOut = alu; WriteData = wd; WriteReg = wr; mem_ack = ack; mem_rdata = rd;
    PCBranch = alu + 32'h100;
  endtask

  // Apply one cycle of inputs; returns just after the mid-cycle model compare.
  task automatic drive(input logic rw, mtr, mw, br, z, input logic [31:0] alu, wd,
                       input logic [4:0] wr, input logic ack, input logic [31:0] rd);
    @(posedge CLK);
    #1;
    set_in(rw, mtr, mw, br, z, alu, wd, wr, ack, rd);
    @(negedge CLK);
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
  endtask

  initial begin
    int stall_cnt, te_cnt, guard;
    set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    RESET = 1'b0;
    #1 RESET = 1'b1;
    chk_en = 1'b1;
    @(negedge CLK); #1;
    chk("rst wb_RegWrite", 32'(wb_RegWrite), 32'h0);
    chk("rst mem_req", 32'(mem_req), 32'h0);
    @(posedge CLK); #1 RESET = 1'b0;
    nop();

    // Load with ack in the 3rd cycle
    drive(1, 1, 0, 0, 0, 32'h10, 32'h0, 5'd5, 0, 32'h0);
    chk("ld req", 32'(mem_req), 32'h1);
    chk("ld addr", mem_addr, 32'h10);
    chk("ld stall1", 32'(Stall), 32'h1);
    drive(1, 1, 0, 0, 0, 32'h10, 32'h0, 5'd5, 0, 32'h0);
    chk("ld stall2", 32'(Stall), 32'h1);
    drive(1, 1, 0, 0, 0, 32'h10, 32'h0, 5'd5, 1, 32'hDEADBEEF);
    chk("ld stall3", 32'(Stall), 32'h0);
    nop();
    chk("ld wb_ReadData", wb_ReadData, 32'hDEADBEEF);
    chk("ld wb_WriteReg", 32'(wb_WriteReg), 32'd5);
    chk("ld wb_RegWrite", 32'(wb_RegWrite), 32'h1);

    // Store acked next cycle
    drive(1, 0, 1, 0, 0, 32'h24, 32'h55AA55AA, 5'd3, 0, 32'h0);
    chk("st we", 32'(mem_we), 32'h1);
    chk("st wdata", mem_wdata, 32'h55AA55AA);
    chk("st stall1", 32'(Stall), 32'h1);
    drive(1, 0, 1, 0, 0, 32'h24, 32'h55AA55AA, 5'd3, 1, 32'h12345678);
    chk("st stall2", 32'(Stall), 32'h0);
    nop();
    chk("st wb_RegWrite", 32'(wb_RegWrite), 32'h0);
    chk("st wb_ReadData", wb_ReadData, 32'h0);

    // Misaligned load
    drive(1, 1, 0, 0, 0, 32'h13, 32'h0, 5'd6, 0, 32'h0);
    chk("mis req", 32'(mem_req), 32'h0);
    chk("mis stall", 32'(Stall), 32'h0);
    nop();
    chk("mis AddrErr", 32'(AddrErr), 32'h1);
    chk("mis wb_RegWrite", 32'(wb_RegWrite), 32'h0);
    nop();
    chk("mis AddrErr clr", 32'(AddrErr), 32'h0);

    // Plain ALU op, WriteReg==0 suppression, ack while idle ignored
    drive(1, 0, 0, 0, 0, 32'hCAFE, 32'h0, 5'd9, 1, 32'hFFFF0000);
    nop();
    chk("alu wb_ALUOut", wb_ALUOut, 32'hCAFE);
    chk("alu wb_RegWrite", 32'(wb_RegWrite), 32'h1);
    drive(1, 0, 0, 0, 0, 32'h77, 32'h0, 5'd0, 0, 32'h0);
    nop();
    chk("r0 wb_RegWrite", 32'(wb_RegWrite), 32'h0);

    // Load and store together behaves as a store
    drive(1, 1, 1, 0, 0, 32'h30, 32'hA5A5A5A5, 5'd7, 0, 32'h0);
    chk("ldst we", 32'(mem_we), 32'h1);
    drive(1, 1, 1, 0, 0, 32'h30, 32'hA5A5A5A5, 5'd7, 1, 32'h1234);
    nop();
    chk("ldst wb_RegWrite", 32'(wb_RegWrite), 32'h0);
    chk("ldst wb_ReadData", wb_ReadData, 32'h0);

    // Branch decisions
    drive(0, 0, 0, 1, 1, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    chk("br taken", 32'(PCSrc), 32'h1);
    drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    chk("br not taken", 32'(PCSrc), 32'h0);

    // Timeout: hold the load while stalled, no ack ever
    stall_cnt = 0; te_cnt = 0; guard = 0;
    drive(1, 1, 0, 0, 0, 32'h40, 32'h0, 5'd4, 0, 32'h0);
    while (Stall === 1'b1 && guard < 40) begin
      stall_cnt++; guard++;
      drive(1, 1, 0, 0, 0, 32'h40, 32'h0, 5'd4, 0, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      nop();
      if (TimeoutErr === 1'b1) te_cnt++;
    end
    chk("to stall cycles", 32'(stall_cnt), 32'd16);
    chk("to pulses", 32'(te_cnt), 32'd1);
    chk("to idle req", 32'(mem_req), 32'h0);

    // Reset mid-WAIT, then a late ack
    drive(1, 1, 0, 0, 0, 32'h50, 32'h0, 5'd8, 0, 32'h0);
    drive(1, 1, 0, 0, 0, 32'h50, 32'h0, 5'd8, 0, 32'h0);
    chk("rw waiting", 32'(mem_req), 32'h1);
    @(posedge CLK); #2;
    RESET = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hBADBAD00;
    #1;
    chk("rw req drop", 32'(mem_req), 32'h0);
    chk("rw stall drop", 32'(Stall), 32'h0);
    chk("rw we drop", 32'(mem_we), 32'h0);
    @(negedge CLK); #1;
    chk("rw wb_RegWrite", 32'(wb_RegWrite), 32'h0);
    chk("rw wb_ReadData", wb_ReadData, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'hBADBAD00);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'hBADBAD00);
    chk("rw late ack req", 32'(mem_req), 32'h0);
    chk("rw late ack rd", wb_ReadData, 32'h0);
    nop();
    nop();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
